pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Front-end sequencer for the 5-stage MIPS pipeline. It drives the PC write enable and the IF/ID register's write-enable and flush, and it drives a bubble into ID/EX. It resolves four hazard sources each cycle: load-use hazards, taken branches and jumps resolved in ID, instruction-fetch misses, and multi-cycle mult/div occupancy. It also keeps a saturating count of front-end stall cycles.

## Interface
Parameters:
- MULDIV_CYCLES, 32: number of frozen cycles after a mult/div issues; must be ≥1.
- CNT_W, 6: width of the mult/div countdown; must satisfy 2^CNT_W ≥ MULDIV_CYCLES.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- idex_mem_read  in  1  the instruction in ID/EX is a load.
- idex_rt  in  5  destination register of the instruction in ID/EX.
- branch_taken  in  1  a branch in ID resolved taken this cycle.
- jump  in  1  a jump was decoded in ID this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- muldiv_start  in  1  a mult/div entered EX this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  synchronous clear of IF/ID to NOP; takes priority over ifid_write.
- idex_bubble  out  1  zeroes the ID/EX control fields.
- state  out  2  current FSM state, for debug.
- stall_cycles  out  32  count of cycles with pc_write=0, saturating.

## Operation
- States: RUN, IMISS, MULDIV.
- Load-use condition: luh = idex_mem_read && idex_rt≠0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
- Redirect condition: redir = branch_taken || jump.
- RUN outputs, first match wins:
  - luh: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. Stay in RUN. luh outranks redir because the branch operands are stale and the branch re-resolves next cycle.
  - redir: pc_write=1, ifid_flush=1, ifid_write=1, idex_bubble=0. Stay in RUN. A concurrent !imem_ready is ignored because that fetch is on the wrong path.
  - !imem_ready: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=0. Go to IMISS.
  - Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- muldiv_start in RUN: go to MULDIV and load cnt=MULDIV_CYCLES-1.
  - This overrides the IMISS transition.
  - It does not change that cycle's outputs.
  - If a fetch miss is still pending, it surfaces in RUN after MULDIV ends.
- IMISS: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=0.
  - On imem_ready=1: the outputs instead become pc_write=1, ifid_write=1, ifid_flush=0, and the FSM returns to RUN.
  - branch_taken, jump and luh are ignored, because IF/ID holds a NOP.
- MULDIV: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - cnt decrements each cycle.
  - When cnt==0, return to RUN at the next edge. This gives exactly MULDIV_CYCLES frozen cycles.
  - All other inputs, including muldiv_start, are ignored.
- stall_cycles increments on every edge where pc_write=0 and the FSM is out of reset. It holds at 32'hFFFF_FFFF and never wraps.
- Outputs are combinational from state and inputs. state, cnt and stall_cycles are registered.

## Timing
- Reset, resetn=0, asynchronous: state=RUN, cnt=0, stall_cycles=0.
  - While resetn=0 the outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  - Reset asserted mid-MULDIV or mid-IMISS aborts immediately.
- First active edge after reset release: normal RUN behaviour.
- Load-use stall lasts 1 cycle. luh drops because the bubble now occupies ID/EX.
- Taken branch or jump penalty: 1 cycle (one NOP in IF/ID).
- Fetch-miss penalty: 1 cycle plus the number of extra cycles imem_ready stays low.
- MULDIV: the muldiv_start cycle is a normal cycle, followed by MULDIV_CYCLES frozen cycles.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state encodings RUN=2'b00, IMISS=2'b01, MULDIV=2'b10 (2'b11 is illegal and recovers to RUN);
  - the NOP constant 32'h0000_0000;
  - the REG_ZERO constant 5'd0.
- One combinational sub-module, load_use_detect, computes luh.
- The FSM, countdown and stall counter live in pipeline_hazard_ctrl.

## Test plan
- Load-use: idex_mem_read=1, idex_rt=5'd8, ifid_rs=5'd8 → exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1. With idex_rt=0 → no stall.
- Branch vs load-use: luh=1 and branch_taken=1 in the same cycle → stall only (ifid_flush=0). Next cycle with luh=0 → ifid_flush=1, pc_write=1.
- Fetch miss: imem_ready low for 3 cycles → pc_write=0 for 3 cycles and state=IMISS on the last 2. Resume with pc_write=1 and stall_cycles=3.
- Mult/div: MULDIV_CYCLES=4, pulse muldiv_start → 4 frozen cycles with idex_bubble=1, then RUN. A second muldiv_start during MULDIV is ignored.
- Simultaneous: muldiv_start=1 with imem_ready=0 → enter MULDIV, not IMISS. After MULDIV ends, with imem_ready still 0 → enter IMISS.
- Reset: assert resetn=0 mid-MULDIV → state=RUN, stall_cycles=0, forced outputs. Separately, preload stall_cycles near max → it saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline front-end hazard controller.
//   state_e  : controller state encoding. 2'b11 is never produced and is
//              treated as an illegal state that recovers to RUN.
//   NOP      : instruction word that a flushed IF/ID holds.
//   REG_ZERO : register $zero. A load that targets it never creates a hazard.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    IMISS  = 2'b01,
    MULDIV = 2'b10
  } state_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector.
// Asserts o_luh when the load in ID/EX writes a register that the
// instruction in IF/ID reads. A load to $zero is excluded.
//   i_ifid_rs, i_ifid_rt : source fields of the instruction in IF/ID
//   i_idex_mem_read      : the instruction in ID/EX is a load
//   i_idex_rt            : load destination register
//   o_luh                : hazard present this cycle
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  output logic       o_luh
);

  logic w_dest_live;
  logic w_src_match;

  assign w_dest_live = i_idex_mem_read && (i_idex_rt != REG_ZERO);
  assign w_src_match = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
  assign o_luh       = w_dest_live && w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencer for the 5-stage MIPS pipeline.
// It resolves these hazards: load-use, ID-resolved redirects, fetch misses
// and mult/div occupancy. It drives the PC / IF/ID enables and the ID/EX
// bubble, and it counts stall cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal flow. Handles load-use, redirect and new fetch misses.
// IMISS  | waiting for imem_ready. IF/ID is held as a NOP.
// MULDIV | front end frozen for MULDIV_CYCLES cycles.
//
// Ports:
//   clock, resetn       : clock and async active-low reset
//   ifid_rs/ifid_rt     : IF/ID source fields
//   idex_mem_read/rt    : load in ID/EX and its destination
//   branch_taken, jump  : redirect decoded in ID
//   imem_ready          : fetch data valid
//   muldiv_start        : mult/div entered EX
//   pc_write, ifid_write, ifid_flush, idex_bubble : pipeline controls
//   state               : current state, for debug
//   stall_cycles        : saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
)(
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        imem_ready,
  input  logic        muldiv_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [31:0]      STALL_MAX = 32'hFFFF_FFFF;

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      r_stall_cycles;

  logic w_luh;
  logic w_redir;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;

  load_use_detect u_luh (
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rt       (ifid_rt),
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rt       (idex_rt),
    .o_luh           (w_luh)
  );

  assign w_redir = branch_taken || jump;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;

    case (r_state)
      RUN: begin
        if (w_luh) begin
          // Redirect waits: branch operands are stale and re-resolve next cycle.
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end else if (w_redir) begin
          // A missing fetch here is wrong-path, so it is dropped.
          w_ifid_flush = 1'b1;
        end else if (!imem_ready) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ifid_flush = 1'b1;
          w_state_next = IMISS;
        end

        // This does not change this cycle's outputs. A pending miss is seen
        // again in RUN after the freeze ends.
        if (muldiv_start) begin
          w_state_next = MULDIV;
          w_cnt_next   = CNT_LOAD;
        end
      end

      IMISS: begin
        if (imem_ready) begin
          w_state_next = RUN;
        end else begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ifid_flush = 1'b1;
        end
      end

      MULDIV: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        if (r_cnt == '0) begin
          w_state_next = RUN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      default: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_state_next  = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!w_pc_write && (r_stall_cycles != STALL_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  // While in reset the front end is held in a safe state: no PC load, and
  // NOPs are forced into both pipeline registers.
  assign pc_write     = resetn ? w_pc_write    : 1'b0;
  assign ifid_write   = resetn ? w_ifid_write  : 1'b0;
  assign ifid_flush   = resetn ? w_ifid_flush  : 1'b1;
  assign idex_bubble  = resetn ? w_idex_bubble : 1'b1;
  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule
